// File: rtl/sync_fifo_flex_if.sv
// sync_fifo_flex_if
// Handshake bundle between a single-clock FIFO and the logic around it.
//   master : the producer/consumer side. It drives clear, wr_en, wr_data and
//            rd_en, and observes data, flags, occupancy and error bits.
//   slave  : the FIFO side.
// DATA_WIDTH and DEPTH must match the sync_fifo_flex instance it connects to.
interface sync_fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, empty, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, empty, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex
// Single-clock FIFO for any DEPTH >= 2, with a selectable read mode
// (FWFT=0: registered read, 1-cycle latency; FWFT=1: first-word-fall-through),
// almost-full/almost-empty thresholds, an occupancy count, sticky
// overflow/underflow flags and a synchronous flush.
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : sync_fifo_flex_if.slave
//             (clear, wr_en/wr_data, rd_en/rd_data, full, almost_full,
//              empty, almost_empty, count, overflow, underflow)
module sync_fifo_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  sync_fifo_flex_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C   = CW'(AEMPTY_THRESH);
  localparam logic [IW-1:0] LAST_IDX_C = IW'(DEPTH - 1);

  // Elaboration-time parameter legality checks
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_flex: FWFT must be 0 or 1");
  end

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX_C) ? {IW{1'b0}} : idx + IW'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [IW-1:0]         wr_idx_r;
  logic [IW-1:0]         rd_idx_r;
  logic [CW-1:0]         count_r;
  logic                  full_r;
  logic                  afull_r;
  logic                  empty_r;
  logic                  aempty_r;
  logic                  ovf_r;
  logic                  unf_r;

  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [CW-1:0]         count_next_s;

  // Accept decisions from registered flags; clear masks both requests
  always_comb begin
    wr_acc_s     = 1'b0;
    rd_acc_s     = 1'b0;
    count_next_s = count_r;
    if (bus.clear) begin
      count_next_s = {CW{1'b0}};
    end else begin
      wr_acc_s     = bus.wr_en & ~full_r;
      rd_acc_s     = bus.rd_en & ~empty_r;
      count_next_s = count_r + {{(CW-1){1'b0}}, wr_acc_s}
                             - {{(CW-1){1'b0}}, rd_acc_s};
    end
  end

  // Indices, count, flags derived from count_next, sticky error bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx_r <= {IW{1'b0}};
      rd_idx_r <= {IW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      empty_r  <= 1'b1;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      count_r  <= count_next_s;
      full_r   <= (count_next_s == DEPTH_C);
      afull_r  <= (count_next_s >= AFULL_C);
      empty_r  <= (count_next_s == {CW{1'b0}});
      aempty_r <= (count_next_s <= AEMPTY_C);
      if (bus.clear) begin
        wr_idx_r <= {IW{1'b0}};
        rd_idx_r <= {IW{1'b0}};
        ovf_r    <= 1'b0;
        unf_r    <= 1'b0;
      end else begin
        if (wr_acc_s) wr_idx_r <= next_idx(wr_idx_r);
        if (rd_acc_s) rd_idx_r <= next_idx(rd_idx_r);
        ovf_r <= ovf_r | (bus.wr_en & full_r);
        unf_r <= unf_r | (bus.rd_en & empty_r);
      end
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) mem_r[wr_idx_r] <= bus.wr_data;
  end

  if (FWFT == 0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Registered read: capture head on an accepted pop, hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (bus.clear) begin
        rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_acc_s) begin
        rd_data_r <= mem_r[rd_idx_r];
      end
    end

    assign bus.rd_data = rd_data_r;
  end else begin : g_fwft_read
    // Head is shown directly; the registered empty flag hides it until the
    // cycle after the write edge, so a fresh write is never shadowed by stale data.
    assign bus.rd_data = empty_r ? {DATA_WIDTH{1'b0}} : mem_r[rd_idx_r];
  end

  assign bus.full         = full_r;
  assign bus.almost_full  = afull_r;
  assign bus.empty        = empty_r;
  assign bus.almost_empty = aempty_r;
  assign bus.count        = count_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;
endmodule
